// File: rtl/uart_fifo16.sv
// 16 x 8 first-word-fall-through FIFO for the UART 16550 TX/RX paths, with registered
// underrun/overrun pulses and a fill-level trigger. Define FIFO_LEVEL_OUT_EN to expose the fill count.
module uart_fifo16 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       threshold,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             underrun,
  output logic             overrun,
  output logic             thre_trig
`ifdef FIFO_LEVEL_OUT_EN
  ,
  output logic [4:0]       level
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [3:0]       rptr_q, rptr_d;
  logic [3:0]       wptr_q, wptr_d;
  logic [4:0]       count_q, count_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;
  logic             push_ok, pop_ok;

  assign empty     = (count_q == 5'd0);
  assign full      = (count_q == 5'(DEPTH));
  assign dout      = mem_q[rptr_q];
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign thre_trig = (count_q >= {1'b0, threshold}) && (count_q != 5'd0);
`ifdef FIFO_LEVEL_OUT_EN
  assign level     = count_q;
`endif

  always_comb begin
    push_ok    = en & push_in & ~full;
    pop_ok     = en & pop_in & ~empty;
    mem_d      = mem_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    underrun_d = en & pop_in & empty;
    overrun_d  = en & push_in & full;
    if (push_ok) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 4'd1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 4'd1;
    end
    // Pointers wrap naturally at 4 bits; count only moves when exactly one side succeeds.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo16.sv
// Directed self-checking bench for uart_fifo16: reset, fill/drain, simultaneous push+pop
// corner cases, enable hold and mid-operation reset.
module tb_uart_fifo16;

  logic       clk;
  logic       rst;
  logic       en;
  logic       push_in;
  logic       pop_in;
  logic [7:0] din;
  logic [3:0] threshold;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       underrun;
  logic       overrun;
  logic       thre_trig;
`ifdef FIFO_LEVEL_OUT_EN
  logic [4:0] level;
`endif

  int n_chk;
  int n_fail;
  logic [7:0] fill [20];

  uart_fifo16 #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .push_in   (push_in),
    .pop_in    (pop_in),
    .din       (din),
    .threshold (threshold),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .underrun  (underrun),
    .overrun   (overrun),
    .thre_trig (thre_trig)
`ifdef FIFO_LEVEL_OUT_EN
    ,
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic e, input logic pu, input logic po, input logic [7:0] d);
    en = e; push_in = pu; pop_in = po; din = d;
    @(posedge clk);
    #1;
    en = 1'b1; push_in = 1'b0; pop_in = 1'b0;
  endtask

  // Infers the fill count by sweeping the threshold around n (effect is combinational).
  task automatic chk_count(input string tag, input int n);
    logic [3:0] saved;
    saved = threshold;
    check({tag, "_empty"}, empty, n == 0);
    check({tag, "_full"}, full, n == 16);
    if (n >= 1 && n <= 15) begin
      threshold = 4'(n);
      #1;
      check({tag, "_ge"}, thre_trig, 1'b1);
      if (n < 15) begin
        threshold = 4'(n + 1);
        #1;
        check({tag, "_lt"}, thre_trig, 1'b0);
      end
    end
    threshold = saved;
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; push_in = 1'b0; pop_in = 1'b0; din = 8'h00; threshold = 4'd10;
    for (int i = 0; i < 20; i++) fill[i] = 8'($urandom);

    // Reset
    repeat (5) @(posedge clk);
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_under", underrun, 1'b0);
    check("rst_over", overrun, 1'b0);
    check("rst_trig", thre_trig, 1'b0);
    rst = 1'b0; en = 1'b1;

    // Fill with 20 pushes
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, fill[i-1]);
      if (i == 1) check("fill_dout_fwft", dout, fill[0]);
      check("fill_trig", thre_trig, i >= 10);
      check("fill_full", full, i >= 16);
      check("fill_over", overrun, i >= 17);
      check("fill_empty", empty, 1'b0);
    end

    // Drain with 20 pops
    for (int j = 1; j <= 20; j++) begin
      if (j <= 16) check("drain_dout", dout, fill[j-1]);
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
      check("drain_trig", thre_trig, (j <= 16) && (16 - j >= 10));
      check("drain_empty", empty, j >= 16);
      check("drain_under", underrun, j >= 17);
      if (j >= 16) check("drain_dout_hold", dout, fill[0]);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("drain_under_clr", underrun, 1'b0);

    // Simultaneous push+pop at count 5
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 8'h10 + 8'(k));
    chk_count("mid5_pre", 5);
    check("mid5_head", dout, 8'h10);
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    chk_count("mid5_post", 5);
    check("mid5_err", {underrun, overrun}, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      check("mid5_order", dout, 8'h10 + 8'(k));
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
    end
    check("mid5_a5", dout, 8'hA5);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    check("mid5_empty", empty, 1'b1);

    // Simultaneous push+pop on a full FIFO
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b0, 8'h40 + 8'(k));
    check("full_pre", full, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 8'h3C);
    check("full_pp_over", overrun, 1'b1);
    chk_count("full_pp_cnt", 15);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("full_pp_over_once", overrun, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      check("full_pp_data", dout, 8'h40 + 8'(k));
      cyc(1'b1, 1'b0, 1'b1, 8'h00);
    end
    check("full_pp_lost", empty, 1'b1);

    // Simultaneous push+pop on an empty FIFO, threshold 0 acting as 1
    threshold = 4'd0;
    #1;
    check("thr0_empty_trig", thre_trig, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    check("empty_pp_under", underrun, 1'b1);
    check("empty_pp_dout", dout, 8'h77);
    check("thr0_trig", thre_trig, 1'b1);
    chk_count("empty_pp_cnt", 1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("empty_pp_under_once", underrun, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    check("empty_pp_drain", empty, 1'b1);
    threshold = 4'd10;

    // en = 0 holds state with both requests asserted
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 8'h50 + 8'(k));
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'hEE);
      check("en0_err", {underrun, overrun}, 2'b00);
      check("en0_dout", dout, 8'h50);
      chk_count("en0_cnt", 4);
    end

    // Reset in the middle of filling, at count 7, with a push pending
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 8'h60 + 8'(k));
    chk_count("pre_rst_cnt", 7);
    rst = 1'b1; push_in = 1'b1; din = 8'h99;
    @(posedge clk);
    #1;
    rst = 1'b0; push_in = 1'b0;
    check("mrst_empty", empty, 1'b1);
    check("mrst_dout", dout, 8'h00);
    check("mrst_full", full, 1'b0);
    check("mrst_trig", thre_trig, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
